sweep_counter_ctrl: RTL and testbench

//  Upstream sequencer for the loaded DSP48 up/down counter. Drives its load/enable/direction/increment

---
 rtl/sweep_counter_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_sweep_counter_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_counter_ctrl.sv
// Triangle-sweep sequencer for a loadable up/down counter, with a shadow position register.
// Optional feedback compare of value_i against the shadow is enabled by defining SWEEP_CHECK_EN.
module sweep_counter_ctrl #(
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned DWELL_WIDTH   = 8,
    parameter int unsigned SWEEP_WIDTH   = 8
) (
    input  logic                     clk_i,
    input  logic                     a_rst_n_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic [COUNTER_WIDTH-1:0] lower_i,
    input  logic [COUNTER_WIDTH-1:0] upper_i,
    input  logic [COUNTER_WIDTH-1:0] step_i,
    input  logic [DWELL_WIDTH-1:0]   dwell_i,
    input  logic [SWEEP_WIDTH-1:0]   cycles_i,
    input  logic [COUNTER_WIDTH-1:0] value_i,
    output logic                     cnt_load_enable_o,
    output logic [COUNTER_WIDTH-1:0] cnt_load_data_o,
    output logic                     cnt_enable_o,
    output logic                     cnt_direction_o,
    output logic [COUNTER_WIDTH-1:0] cnt_increment_o,
    output logic                     busy_o,
    output logic                     turn_o,
    output logic                     done_o,
    output logic                     cfg_err_o,
    output logic                     mismatch_o
);

    typedef enum logic [2:0] {StIdle, StLoad, StUp, StDwellHi, StDown, StDwellLo} state_e;

    state_e                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] pos_q, pos_d;
    logic [COUNTER_WIDTH-1:0] lower_q, lower_d, upper_q, upper_d, step_q, step_d;
    logic [DWELL_WIDTH-1:0]   dwell_q, dwell_d, dwell_cnt_q, dwell_cnt_d;
    logic [SWEEP_WIDTH-1:0]   cycles_q, cycles_d, sweep_q, sweep_d, sweep_inc;
    logic                     load_en_q, load_en_d, en_q, en_d, dir_q, dir_d;
    logic [COUNTER_WIDTH-1:0] load_data_q, load_data_d, inc_q, inc_d;
    logic                     busy_q, busy_d, turn_q, turn_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic                     cfg_bad;

    assign cfg_bad   = (step_i == '0) || (lower_i > upper_i);
    assign sweep_inc = sweep_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        lower_d     = lower_q;
        upper_d     = upper_q;
        step_d      = step_q;
        dwell_d     = dwell_q;
        cycles_d    = cycles_q;
        sweep_d     = sweep_q;
        dwell_cnt_d = dwell_cnt_q;
        load_en_d   = 1'b0;
        load_data_d = '0;
        en_d        = 1'b0;
        dir_d       = 1'b0;
        inc_d       = '0;
        turn_d      = 1'b0;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        if (stop_i && state_q != StIdle) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i && !stop_i) begin
                        if (cfg_bad) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            lower_d  = lower_i;
                            upper_d  = upper_i;
                            step_d   = step_i;
                            dwell_d  = dwell_i;
                            cycles_d = cycles_i;
                            sweep_d  = '0;
                            state_d  = StLoad;
                        end
                    end
                end
                StLoad: begin
                    load_en_d   = 1'b1;
                    load_data_d = lower_q;
                    pos_d       = lower_q;
                    state_d     = StUp;
                end
                // Strict '>' so a bound is always reached by a load, never by a step.
                StUp: begin
                    if ((upper_q - pos_q) > step_q) begin
                        en_d  = 1'b1;
                        dir_d = 1'b1;
                        inc_d = step_q;
                        pos_d = pos_q + step_q;
                    end else begin
                        load_en_d   = 1'b1;
                        load_data_d = upper_q;
                        pos_d       = upper_q;
                        turn_d      = 1'b1;
                        if (dwell_q == '0) begin
                            state_d = StDown;
                        end else begin
                            dwell_cnt_d = dwell_q - 1'b1;
                            state_d     = StDwellHi;
                        end
                    end
                end
                StDown: begin
                    if ((pos_q - lower_q) > step_q) begin
                        en_d  = 1'b1;
                        inc_d = step_q;
                        pos_d = pos_q - step_q;
                    end else begin
                        load_en_d   = 1'b1;
                        load_data_d = lower_q;
                        pos_d       = lower_q;
                        sweep_d     = sweep_inc;
                        if (cycles_q != '0 && sweep_inc == cycles_q) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            turn_d = 1'b1;
                            if (dwell_q == '0) begin
                                state_d = StUp;
                            end else begin
                                dwell_cnt_d = dwell_q - 1'b1;
                                state_d     = StDwellLo;
                            end
                        end
                    end
                end
                StDwellHi, StDwellLo: begin
                    if (dwell_cnt_q == '0) begin
                        state_d = (state_q == StDwellHi) ? StDown : StUp;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_q     <= StIdle;
            pos_q       <= '0;
            lower_q     <= '0;
            upper_q     <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            cycles_q    <= '0;
            sweep_q     <= '0;
            dwell_cnt_q <= '0;
            load_en_q   <= 1'b0;
            load_data_q <= '0;
            en_q        <= 1'b0;
            dir_q       <= 1'b0;
            inc_q       <= '0;
            busy_q      <= 1'b0;
            turn_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            lower_q     <= lower_d;
            upper_q     <= upper_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            cycles_q    <= cycles_d;
            sweep_q     <= sweep_d;
            dwell_cnt_q <= dwell_cnt_d;
            load_en_q   <= load_en_d;
            load_data_q <= load_data_d;
            en_q        <= en_d;
            dir_q       <= dir_d;
            inc_q       <= inc_d;
            busy_q      <= busy_d;
            turn_q      <= turn_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign cnt_load_enable_o = load_en_q;
    assign cnt_load_data_o   = load_data_q;
    assign cnt_enable_o      = en_q;
    assign cnt_direction_o   = dir_q;
    assign cnt_increment_o   = inc_q;
    assign busy_o            = busy_q;
    assign turn_o            = turn_q;
    assign done_o            = done_q;
    assign cfg_err_o         = cfg_err_q;

`ifdef SWEEP_CHECK_EN
    // The counter lags the shadow by one edge; comparing starts once the LOAD has landed.
    logic [COUNTER_WIDTH-1:0] pos_dly_q;
    logic                     load_seen_q, check_q, mismatch_q, accept;

    assign accept = (state_q == StIdle) && start_i && !stop_i && !cfg_bad;

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            pos_dly_q   <= '0;
            load_seen_q <= 1'b0;
            check_q     <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            pos_dly_q   <= pos_q;
            load_seen_q <= (state_q == StLoad);
            check_q     <= (state_d != StIdle) && (check_q || load_seen_q);
            if (accept) begin
                mismatch_q <= 1'b0;
            end else if (check_q && (value_i != pos_dly_q)) begin
                mismatch_q <= 1'b1;
            end
        end
    end

    assign mismatch_o = mismatch_q;
`else
    logic unused_value;
    assign unused_value = ^value_i;
    assign mismatch_o   = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Directed bench for sweep_counter_ctrl, driving a behavioural model of the downstream counter.
module tb_sweep_counter_ctrl;

    logic       clk_i = 1'b0;
    logic       a_rst_n_i, start_i, stop_i;
    logic [7:0] lower_i, upper_i, step_i, dwell_i, cycles_i, value_i;
    logic       cnt_load_enable_o, cnt_enable_o, cnt_direction_o;
    logic [7:0] cnt_load_data_o, cnt_increment_o;
    logic       busy_o, turn_o, done_o, cfg_err_o, mismatch_o;

    logic [7:0] cnt_val;
    logic [7:0] corrupt;
    logic [7:0] trace[$];
    int turns = 0, dones = 0, errs = 0, gaps = 0, overlaps = 0, busy_cyc = 0;
    int n_cmp = 0, n_fail = 0;
    int s_trace, s_turns, s_dones, s_errs, s_gaps, s_busy;
    int cyc;
    bit found;

    always #5 clk_i = ~clk_i;

    sweep_counter_ctrl dut (
        .clk_i             (clk_i),
        .a_rst_n_i         (a_rst_n_i),
        .start_i           (start_i),
        .stop_i            (stop_i),
        .lower_i           (lower_i),
        .upper_i           (upper_i),
        .step_i            (step_i),
        .dwell_i           (dwell_i),
        .cycles_i          (cycles_i),
        .value_i           (value_i),
        .cnt_load_enable_o (cnt_load_enable_o),
        .cnt_load_data_o   (cnt_load_data_o),
        .cnt_enable_o      (cnt_enable_o),
        .cnt_direction_o   (cnt_direction_o),
        .cnt_increment_o   (cnt_increment_o),
        .busy_o            (busy_o),
        .turn_o            (turn_o),
        .done_o            (done_o),
        .cfg_err_o         (cfg_err_o),
        .mismatch_o        (mismatch_o)
    );

    assign value_i = cnt_val ^ corrupt;

    function automatic logic [7:0] step_val(input logic [7:0] v, input logic up, input logic [7:0] inc);
        return up ? v + inc : v - inc;
    endfunction

    // Downstream counter: load has priority over enable.
    always @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            cnt_val <= '0;
        end else if (cnt_load_enable_o) begin
            cnt_val <= cnt_load_data_o;
            trace.push_back(cnt_load_data_o);
        end else if (cnt_enable_o) begin
            cnt_val <= step_val(cnt_val, cnt_direction_o, cnt_increment_o);
            trace.push_back(step_val(cnt_val, cnt_direction_o, cnt_increment_o));
        end
    end

    always @(negedge clk_i) begin
        turns    <= turns + (turn_o ? 1 : 0);
        dones    <= dones + (done_o ? 1 : 0);
        errs     <= errs + (cfg_err_o ? 1 : 0);
        gaps     <= gaps + ((busy_o && !cnt_load_enable_o && !cnt_enable_o) ? 1 : 0);
        overlaps <= overlaps + ((cnt_load_enable_o && cnt_enable_o) ? 1 : 0);
        busy_cyc <= busy_cyc + (busy_o ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected values packed 8 bits each, first value in the most significant used byte.
    task automatic chk_trace(input string tag, input int n, input logic [127:0] pk);
        chk({tag, "_len"}, trace.size() - s_trace, n);
        for (int i = 0; i < n; i++) begin
            if (s_trace + i < trace.size())
                chk($sformatf("%s_v%0d", tag, i), trace[s_trace + i], pk[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic snap();
        s_trace = trace.size();
        s_turns = turns;
        s_dones = dones;
        s_errs  = errs;
        s_gaps  = gaps;
        s_busy  = busy_cyc;
    endtask

    task automatic cfg(input logic [7:0] lo, up, st, dw, cy);
        lower_i  = lo;
        upper_i  = up;
        step_i   = st;
        dwell_i  = dw;
        cycles_i = cy;
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        cyc = 0;
        while (busy_o && cyc < budget) begin
            @(negedge clk_i);
            cyc++;
        end
        if (busy_o) chk({tag, "_timeout"}, busy_o, 1'b0);
    endtask

    task automatic all_outputs(input string tag);
        chk(tag, {cnt_load_enable_o, cnt_load_data_o, cnt_enable_o, cnt_direction_o,
                  cnt_increment_o, busy_o, turn_o, done_o, cfg_err_o, mismatch_o}, 32'd0);
    endtask

    initial begin
        a_rst_n_i = 1'b0;
        start_i   = 1'b0;
        stop_i    = 1'b0;
        corrupt   = '0;
        cfg(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (2) @(negedge clk_i);
        all_outputs("reset_outputs");
        a_rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("idle_busy", busy_o, 1'b0);

        // Plain triangle, distance not a multiple of step.
        snap();
        cfg(8'd10, 8'd20, 8'd3, 8'd0, 8'd1);
        pulse_start();
        wait_idle("t1", 100);
        chk("t1_done_at_busy_fall", done_o, 1'b1);
        repeat (3) @(negedge clk_i);
        chk_trace("t1_trace", 9, {8'd10, 8'd13, 8'd16, 8'd19, 8'd20, 8'd17, 8'd14, 8'd11, 8'd10});
        chk("t1_turns", turns - s_turns, 1);
        chk("t1_dones", dones - s_dones, 1);
        chk("t1_gaps", gaps - s_gaps, 1);
        chk("t1_counter", cnt_val, 8'd10);

        // Near the top of the range: must clamp at 255 rather than wrap.
        snap();
        cfg(8'd240, 8'd255, 8'd10, 8'd0, 8'd1);
        pulse_start();
        wait_idle("t2", 100);
        repeat (3) @(negedge clk_i);
        chk_trace("t2_trace", 5, {8'd240, 8'd250, 8'd255, 8'd245, 8'd240});
        chk("t2_dones", dones - s_dones, 1);

        // Dwell at each bound, two sweeps, distance an exact multiple of step.
        snap();
        cfg(8'd0, 8'd4, 8'd2, 8'd2, 8'd2);
        pulse_start();
        wait_idle("t3", 200);
        repeat (3) @(negedge clk_i);
        chk_trace("t3_trace", 9, {8'd0, 8'd2, 8'd4, 8'd2, 8'd0, 8'd2, 8'd4, 8'd2, 8'd0});
        chk("t3_turns", turns - s_turns, 3);
        chk("t3_dones", dones - s_dones, 1);
        chk("t3_gaps", gaps - s_gaps, 7);

        // Rejected configurations.
        snap();
        cfg(8'd1, 8'd5, 8'd0, 8'd0, 8'd1);
        pulse_start();
        chk("t4_err_step0", cfg_err_o, 1'b1);
        cfg(8'd9, 8'd3, 8'd1, 8'd0, 8'd1);
        pulse_start();
        chk("t4_err_order", cfg_err_o, 1'b1);
        repeat (3) @(negedge clk_i);
        chk("t4_errs", errs - s_errs, 2);
        chk("t4_busy_cycles", busy_cyc - s_busy, 0);
        chk("t4_no_trace", trace.size() - s_trace, 0);

        // Endless sweep, aborted on the way up once the shadow reaches 13.
        snap();
        cfg(8'd10, 8'd20, 8'd3, 8'd0, 8'd0);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (trace.size() - s_trace >= 9 && cnt_val == 8'd10 && cnt_enable_o && cnt_direction_o)
                found = 1'b1;
            else
                @(negedge clk_i);
        end
        chk("t5_second_sweep_reached", found, 1'b1);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        chk("t5_busy_after_stop", busy_o, 1'b0);
        chk("t5_strobes", {cnt_load_enable_o, cnt_enable_o}, 2'b00);
        chk("t5_counter", cnt_val, 8'd13);
        repeat (3) @(negedge clk_i);
        chk("t5_counter_hold", cnt_val, 8'd13);
        chk("t5_no_done", dones - s_dones, 0);

        // Asynchronous reset in the middle of an up ramp.
        cfg(8'd10, 8'd20, 8'd3, 8'd0, 8'd0);
        pulse_start();
        repeat (3) @(negedge clk_i);
        chk("t6_busy_before_reset", busy_o, 1'b1);
        #2;
        a_rst_n_i = 1'b0;
        #1;
        all_outputs("t6_async_reset");
        @(negedge clk_i);
        a_rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("t6_no_restart", busy_o, 1'b0);

        // Degenerate range: each pair of bound loads is one sweep.
        snap();
        cfg(8'd5, 8'd5, 8'd1, 8'd0, 8'd2);
        pulse_start();
        wait_idle("t7", 100);
        repeat (3) @(negedge clk_i);
        chk_trace("t7_trace", 5, {8'd5, 8'd5, 8'd5, 8'd5, 8'd5});
        chk("t7_turns", turns - s_turns, 3);
        chk("t7_dones", dones - s_dones, 1);
        chk("overlaps", overlaps, 0);

`ifdef SWEEP_CHECK_EN
        chk("t8_clean", mismatch_o, 1'b0);
        cfg(8'd10, 8'd20, 8'd3, 8'd0, 8'd0);
        pulse_start();
        repeat (4) @(negedge clk_i);
        corrupt = 8'd1;
        @(negedge clk_i);
        corrupt = 8'd0;
        @(negedge clk_i);
        chk("t8_mismatch_set", mismatch_o, 1'b1);
        repeat (3) @(negedge clk_i);
        chk("t8_mismatch_sticky", mismatch_o, 1'b1);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        pulse_start();
        chk("t8_mismatch_cleared", mismatch_o, 1'b0);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
`else
        chk("t8_mismatch_tied", mismatch_o, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
